// File: rtl/regbus_bridge.sv
// Host bus to register_set bridge: turns Wishbone-classic single transfers into
// one-cycle register commands and returns a one-cycle ack or err.
module regbus_bridge #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_host_cyc,
   input  logic                    i_host_stb,
   input  logic                    i_host_we,
   input  logic [ADDR_WIDTH-1:0]   i_host_adr,
   input  logic [3:0]              i_host_sel,
   input  logic [4*DATA_WIDTH-1:0] i_host_dat_w,
   output logic [4*DATA_WIDTH-1:0] o_host_dat_r,
   output logic                    o_host_ack,
   output logic                    o_host_err,
   output logic                    o_reg_wnr,
   output logic [1:0]              o_reg_req,
   output logic [ADDR_WIDTH-1:0]   o_reg_address,
   output logic [4*DATA_WIDTH-1:0] o_reg_wdata,
   input  logic                    i_reg_ack,
   input  logic [4*DATA_WIDTH-1:0] i_reg_rdata,
   output logic [2:0]              o_state
);

   localparam int BUS_W = 4 * DATA_WIDTH;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   // Handshake: a request is valid when cyc & stb are high and is accepted only
   // on an edge where the bridge sits in IDLE; completion is a single-cycle
   // ack or err, after which the master must have dropped stb.

   state_t                  r_state, w_state_nxt;
   logic [1:0]              r_req, w_req_nxt;
   logic                    r_wnr, w_wnr_nxt;
   logic [ADDR_WIDTH-1:0]   r_address, w_address_nxt;
   logic [BUS_W-1:0]        r_wdata, w_wdata_nxt;
   logic [BUS_W-1:0]        r_dat_r, w_dat_r_nxt;
   logic                    r_ack, w_ack_nxt;
   logic                    r_err, w_err_nxt;
   logic [1:0]              r_lane, w_lane_nxt;
   logic [3:0]              r_sel, w_sel_nxt;
   logic [7:0]              r_cnt, w_cnt_nxt;

   logic                    w_dec_legal;
   logic [1:0]              w_dec_req;
   logic [1:0]              w_dec_lane;
   logic [BUS_W-1:0]        w_wdata_shifted;
   logic [BUS_W-1:0]        w_lane_mask;
   logic [BUS_W-1:0]        w_rdata_aligned;
   logic                    w_unused_adr;

   // Byte address bits [1:0] are replaced by the decoded lane.
   assign w_unused_adr = ^i_host_adr[1:0];

   always_comb begin
      w_dec_legal = 1'b1;
      w_dec_req   = 2'd1;
      w_dec_lane  = 2'd0;
      case (i_host_sel)
         4'b0001: begin w_dec_req = 2'd1; w_dec_lane = 2'd0; end
         4'b0010: begin w_dec_req = 2'd1; w_dec_lane = 2'd1; end
         4'b0100: begin w_dec_req = 2'd1; w_dec_lane = 2'd2; end
         4'b1000: begin w_dec_req = 2'd1; w_dec_lane = 2'd3; end
         4'b0011: begin w_dec_req = 2'd2; w_dec_lane = 2'd0; end
         4'b1100: begin w_dec_req = 2'd2; w_dec_lane = 2'd2; end
         4'b1111: begin w_dec_req = 2'd3; w_dec_lane = 2'd0; end
         default: begin w_dec_legal = 1'b0; w_dec_req = 2'd0; end
      endcase
   end

   assign w_wdata_shifted = i_host_dat_w >> (DATA_WIDTH * int'(w_dec_lane));

   // The latched select doubles as the lane mask for returned read data.
   always_comb begin
      w_lane_mask = '0;
      for (int i = 0; i < 4; i++) begin
         w_lane_mask[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{r_sel[i]}};
      end
   end

   assign w_rdata_aligned = (i_reg_rdata << (DATA_WIDTH * int'(r_lane))) & w_lane_mask;

   always_comb begin
      w_state_nxt   = r_state;
      w_req_nxt     = 2'd0;
      w_wnr_nxt     = r_wnr;
      w_address_nxt = r_address;
      w_wdata_nxt   = r_wdata;
      w_dat_r_nxt   = '0;
      w_ack_nxt     = 1'b0;
      w_err_nxt     = 1'b0;
      w_lane_nxt    = r_lane;
      w_sel_nxt     = r_sel;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (i_host_cyc && i_host_stb) begin
               if (w_dec_legal) begin
                  w_state_nxt   = S_ISSUE;
                  w_req_nxt     = w_dec_req;
                  w_wnr_nxt     = i_host_we;
                  w_address_nxt = {i_host_adr[ADDR_WIDTH-1:2], w_dec_lane};
                  w_wdata_nxt   = w_wdata_shifted;
                  w_lane_nxt    = w_dec_lane;
                  w_sel_nxt     = i_host_sel;
               end else begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_reg_ack) begin
               w_state_nxt = S_RESP;
               w_ack_nxt   = 1'b1;
               w_dat_r_nxt = r_wnr ? '0 : w_rdata_aligned;
            end else if (r_cnt == TO_LAST) begin
               w_state_nxt = S_ERR;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_req     <= 2'd0;
         r_wnr     <= 1'b0;
         r_address <= '0;
         r_wdata   <= '0;
         r_dat_r   <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_lane    <= 2'd0;
         r_sel     <= 4'd0;
         r_cnt     <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_req     <= w_req_nxt;
         r_wnr     <= w_wnr_nxt;
         r_address <= w_address_nxt;
         r_wdata   <= w_wdata_nxt;
         r_dat_r   <= w_dat_r_nxt;
         r_ack     <= w_ack_nxt;
         r_err     <= w_err_nxt;
         r_lane    <= w_lane_nxt;
         r_sel     <= w_sel_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign o_host_dat_r  = r_dat_r;
   assign o_host_ack    = r_ack;
   assign o_host_err    = r_err;
   assign o_reg_wnr     = r_wnr;
   assign o_reg_req     = r_req;
   assign o_reg_address = r_address;
   assign o_reg_wdata   = r_wdata;
   assign o_state       = r_state;

endmodule

// File: tb/tb_regbus_bridge.sv
// Directed and random bench for regbus_bridge with a behavioural register_set
// model, a host-level shadow memory and an expected-read-data queue.
module tb_regbus_bridge;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int W  = 32;

   logic          clk;
   logic          reset;
   logic          host_cyc, host_stb, host_we;
   logic [AW-1:0] host_adr;
   logic [3:0]    host_sel;
   logic [W-1:0]  host_dat_w, host_dat_r;
   logic          host_ack, host_err;
   logic          reg_wnr;
   logic [1:0]    reg_req;
   logic [AW-1:0] reg_address;
   logic [W-1:0]  reg_wdata, reg_rdata;
   logic          reg_ack;
   logic [2:0]    state;

   logic          model_init, m_ack_en, inj_ack, m_ack;
   logic [7:0]    mem [0:255];
   logic [7:0]    sh  [0:255];
   int            req_cnt, viol_req, viol_both;
   logic [1:0]    prev_req;
   logic [W-1:0]  exp_q[$];
   int            n_assert, n_fail;

   regbus_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset),
      .i_host_cyc(host_cyc), .i_host_stb(host_stb), .i_host_we(host_we),
      .i_host_adr(host_adr), .i_host_sel(host_sel), .i_host_dat_w(host_dat_w),
      .o_host_dat_r(host_dat_r), .o_host_ack(host_ack), .o_host_err(host_err),
      .o_reg_wnr(reg_wnr), .o_reg_req(reg_req), .o_reg_address(reg_address),
      .o_reg_wdata(reg_wdata), .i_reg_ack(reg_ack), .i_reg_rdata(reg_rdata),
      .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign reg_ack = m_ack | inj_ack;

   function automatic int nbytes(input logic [1:0] rq);
      return (rq == 2'd3) ? 4 : int'(rq);
   endfunction

   // Unused upper bytes carry 0xEE so lane masking in the bridge is exercised.
   function automatic logic [W-1:0] model_read(input logic [7:0] a, input logic [1:0] rq);
      logic [W-1:0] r;
      r = {4{8'hEE}};
      for (int b = 0; b < 4; b++)
         if (b < nbytes(rq)) r[b*8 +: 8] = mem[8'(a + 8'(b))];
      return r;
   endfunction

   // register_set model: executes on every cycle req is non-zero, acks next cycle.
   always @(posedge clk) begin
      if (model_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         m_ack     <= 1'b0;
         reg_rdata <= '0;
         req_cnt   <= 0;
      end else begin
         m_ack <= 1'b0;
         if (reg_req != 2'd0) begin
            req_cnt <= req_cnt + 1;
            if (m_ack_en) begin
               m_ack <= 1'b1;
               if (reg_wnr) begin
                  for (int b = 0; b < 4; b++)
                     if (b < nbytes(reg_req)) mem[8'(reg_address + 8'(b))] <= reg_wdata[b*8 +: 8];
               end else begin
                  reg_rdata <= model_read(reg_address, reg_req);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_init) begin
         prev_req  <= 2'd0;
         viol_req  <= 0;
         viol_both <= 0;
      end else begin
         prev_req <= reg_req;
         if (reg_req != 2'd0 && prev_req != 2'd0) viol_req <= viol_req + 1;
         if (host_ack && host_err) viol_both <= viol_both + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic do_xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                          input logic [W-1:0] dw,
                          output logic [1:0] c_req, output logic [7:0] c_addr,
                          output logic [W-1:0] c_wdata, output logic [W-1:0] dr,
                          output int lat, output logic ga, output logic ge, output int nr);
      int rc0;
      rc0 = req_cnt;
      host_cyc = 1'b1; host_stb = 1'b1; host_we = we;
      host_adr = adr;  host_sel = sel;  host_dat_w = dw;
      tick();
      host_stb = 1'b0;
      c_req = reg_req; c_addr = reg_address; c_wdata = reg_wdata;
      lat = 1;
      while (!host_ack && !host_err && lat < 40) begin
         tick();
         lat++;
      end
      ga = host_ack; ge = host_err; dr = host_dat_r;
      host_cyc = 1'b0;
      tick();
      chk("pulse_one_cycle", 32'({host_ack, host_err}), 32'd0);
      nr = req_cnt - rc0;
   endtask

   task automatic xfer_sb(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                          input logic [W-1:0] dw,
                          output logic [1:0] c_req, output logic [7:0] c_addr,
                          output logic [W-1:0] c_wdata, output logic [W-1:0] dr);
      logic [W-1:0] e;
      int lat, nr;
      logic ga, ge;
      e = '0;
      if (!we)
         for (int i = 0; i < 4; i++)
            if (sel[i]) e[i*8 +: 8] = sh[{adr[7:2], 2'(i)}];
      exp_q.push_back(e);
      do_xfer(we, adr, sel, dw, c_req, c_addr, c_wdata, dr, lat, ga, ge, nr);
      e = exp_q.pop_front();
      chk("ack_seen", 32'(ga), 32'd1);
      chk("no_err", 32'(ge), 32'd0);
      chk("ack_latency", 32'(lat), 32'd3);
      chk("one_command", 32'(nr), 32'd1);
      if (ga) chk("sb_dat_r", dr, e);
      if (we && ga)
         for (int i = 0; i < 4; i++)
            if (sel[i]) sh[{adr[7:2], 2'(i)}] = dw[i*8 +: 8];
      chk("req_single_cycle", 32'(viol_req), 32'd0);
      chk("ack_err_exclusive", 32'(viol_both), 32'd0);
   endtask

   initial begin
      logic [1:0]   c_req;
      logic [7:0]   c_addr;
      logic [W-1:0] c_wdata, dr;
      int           lat, nr;
      logic         ga, ge;
      logic [3:0]   legal_sel [7];

      n_assert = 0; n_fail = 0;
      legal_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      for (int i = 0; i < 256; i++) sh[i] = 8'h00;
      host_cyc = 1'b0; host_stb = 1'b0; host_we = 1'b0;
      host_adr = '0; host_sel = '0; host_dat_w = '0;
      m_ack_en = 1'b1; inj_ack = 1'b0;
      model_init = 1'b1; reset = 1'b1;

      // Reset state
      tick(); tick();
      model_init = 1'b0;
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_reg_req", 32'(reg_req), 32'd0);
      chk("rst_reg_wnr", 32'(reg_wnr), 32'd0);
      chk("rst_reg_address", 32'(reg_address), 32'd0);
      chk("rst_reg_wdata", reg_wdata, 32'd0);
      chk("rst_host_dat_r", host_dat_r, 32'd0);
      chk("rst_ack_err", 32'({host_ack, host_err}), 32'd0);
      reset = 1'b0;
      tick();

      // Byte write then read back on lane 2
      xfer_sb(1'b1, 8'h10, 4'b0100, 32'h00AB0000, c_req, c_addr, c_wdata, dr);
      chk("bw_reg_address", 32'(c_addr), 32'h12);
      chk("bw_reg_req", 32'(c_req), 32'd1);
      chk("bw_reg_wdata", c_wdata, 32'h000000AB);
      chk("bw_dat_r", dr, 32'd0);
      xfer_sb(1'b0, 8'h10, 4'b0100, 32'hFFFFFFFF, c_req, c_addr, c_wdata, dr);
      chk("br_dat_r", dr, 32'h00AB0000);

      // Half write, word read
      xfer_sb(1'b1, 8'h20, 4'b1100, 32'hBEEF0000, c_req, c_addr, c_wdata, dr);
      chk("hw_reg_address", 32'(c_addr), 32'h22);
      chk("hw_reg_req", 32'(c_req), 32'd2);
      chk("hw_reg_wdata", c_wdata, 32'h0000BEEF);
      xfer_sb(1'b0, 8'h20, 4'b1111, 32'h0, c_req, c_addr, c_wdata, dr);
      chk("wr_reg_req", 32'(c_req), 32'd3);
      chk("wr_reg_address", 32'(c_addr), 32'h20);
      chk("wr_upper_half", 32'(dr[31:16]), 32'hBEEF);
      chk("wr_dat_r", dr, 32'hBEEF0000);

      // Top-of-map lane insertion, no wrap
      xfer_sb(1'b1, 8'hFC, 4'b1000, 32'h5A000000, c_req, c_addr, c_wdata, dr);
      chk("top_reg_address", 32'(c_addr), 32'hFF);
      chk("top_reg_wdata", c_wdata, 32'h0000005A);
      xfer_sb(1'b0, 8'hFC, 4'b1111, 32'h0, c_req, c_addr, c_wdata, dr);
      chk("top_word_read", dr, 32'h5A000000);
      xfer_sb(1'b0, 8'h20, 4'b0011, 32'h0, c_req, c_addr, c_wdata, dr);
      chk("low_half_masked", dr, 32'h00000000);

      // Illegal selects
      do_xfer(1'b1, 8'h30, 4'b0101, 32'h12345678, c_req, c_addr, c_wdata, dr, lat, ga, ge, nr);
      chk("ill_err", 32'(ge), 32'd1);
      chk("ill_no_ack", 32'(ga), 32'd0);
      chk("ill_latency", 32'(lat), 32'd1);
      chk("ill_reg_req", 32'(c_req), 32'd0);
      chk("ill_no_command", 32'(nr), 32'd0);
      do_xfer(1'b0, 8'h30, 4'b0000, 32'h0, c_req, c_addr, c_wdata, dr, lat, ga, ge, nr);
      chk("sel0_err", 32'(ge), 32'd1);
      chk("sel0_no_command", 32'(nr), 32'd0);

      // Timeout with no register ack, then a stray late ack
      m_ack_en = 1'b0;
      do_xfer(1'b1, 8'h40, 4'b1111, 32'h11223344, c_req, c_addr, c_wdata, dr, lat, ga, ge, nr);
      chk("to_err", 32'(ge), 32'd1);
      chk("to_no_ack", 32'(ga), 32'd0);
      chk("to_latency", 32'(lat), 32'd17);
      chk("to_dat_r", dr, 32'd0);
      chk("to_one_command", 32'(nr), 32'd1);
      m_ack_en = 1'b1;
      inj_ack = 1'b1;
      tick();
      inj_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("late_ack_ignored", 32'({host_ack, host_err}), 32'd0);
         chk("late_ack_idle", 32'(state), 32'd0);
         tick();
      end

      // Reset while waiting for the register ack
      host_cyc = 1'b1; host_stb = 1'b1; host_we = 1'b0;
      host_adr = 8'h10; host_sel = 4'b0100;
      tick();
      host_stb = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_outputs", 32'({host_ack, host_err, reg_wnr, reg_req}), 32'd0);
      chk("mid_rst_address", 32'(reg_address), 32'd0);
      chk("mid_rst_wdata", reg_wdata, 32'd0);
      chk("mid_rst_dat_r", host_dat_r, 32'd0);
      reset = 1'b0; host_cyc = 1'b0;
      tick();
      chk("post_rst_quiet", 32'({host_ack, host_err}), 32'd0);
      tick();
      chk("post_rst_quiet2", 32'({host_ack, host_err}), 32'd0);
      xfer_sb(1'b0, 8'h10, 4'b0100, 32'h0, c_req, c_addr, c_wdata, dr);
      chk("post_rst_read", dr, 32'h00AB0000);

      // Random back-to-back legal transfers
      for (int n = 0; n < 100; n++) begin
         logic [7:0] a;
         a = {6'($urandom_range(0, 63)), 2'b00};
         xfer_sb(1'($urandom_range(0, 1)), a, legal_sel[$urandom_range(0, 6)],
                 32'($urandom()), c_req, c_addr, c_wdata, dr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
